// File: rtl/seg_scan_rx.sv
`default_nettype none
// seg_scan_rx: 6-digit multiplexed 7-segment bus receiver; demuxes, decodes to BCD, rebuilds min:sec. Rev 1.0
// Optional feature macro SEG_SCAN_RX_DP_MODE_EN: recover the clock mode from the digit0/digit1 decimal points.
module seg_scan_rx #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_seg_enb,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  output logic [23:0] o_digit,
  output logic [5:0]  o_dp,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic        o_time_vld,
  output logic        o_frame_vld,
  output logic        o_link_up,
  output logic        o_enb_err,
  output logic        o_seg_err,
  output logic [1:0]  o_mode
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [13:0]      SYNC_RST    = {6'h3F, 7'h00, 1'b0};

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] d;
    case (s)
      7'h7E:   d = 4'd0;
      7'h30:   d = 4'd1;
      7'h6D:   d = 4'd2;
      7'h79:   d = 4'd3;
      7'h33:   d = 4'd4;
      7'h5B:   d = 4'd5;
      7'h5F:   d = 4'd6;
      7'h70:   d = 4'd7;
      7'h7F:   d = 4'd8;
      7'h73:   d = 4'd9;
      7'h00:   d = 4'hF;
      default: d = 4'hE;
    endcase
    return d;
  endfunction

  // {enb, seg, dp} through two flops; prev_q holds the last synced word for change detection
  logic [13:0] meta_q, sync_q, prev_q;
  logic [5:0]  enb_s;
  logic [6:0]  seg_s;
  logic        dp_s;
  logic        enb_chg, any_chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
      prev_q <= SYNC_RST;
    end else begin
      meta_q <= {i_seg_enb, i_seg, i_seg_dp};
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign enb_s   = sync_q[13:8];
  assign seg_s   = sync_q[7:1];
  assign dp_s    = sync_q[0];
  assign enb_chg = (enb_s != prev_q[13:8]);
  assign any_chg = (sync_q != prev_q);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d, tcnt_q, tcnt_d;
  logic [23:0]       shd_dig_q, shd_dig_d;
  logic [5:0]        shd_dp_q, shd_dp_d;
  logic [5:0]        mask_q, mask_d;
  logic [23:0]       digit_q, digit_d;
  logic [5:0]        dp_q, dp_d;
  logic [5:0]        sec_q, sec_d, min_q, min_d;
  logic              tvld_q, tvld_d;
  logic              fvld_q, fvld_d;
  logic              link_q, link_d;
  logic              enb_err_q, enb_err_d;
  logic              seg_err_q, seg_err_d;

  logic [5:0]  enb_low;
  logic        one_low, multi_low;
  logic [3:0]  dec;
  logic [5:0]  mask_new;
  logic [23:0] shd_new_dig;
  logic [5:0]  shd_new_dp;
  logic [3:0]  d0, d1, d2, d3;
  logic        tv_new;
  logic [5:0]  sec_new, min_new;
  logic        tmo;

  assign enb_low   = ~enb_s;
  assign one_low   = (enb_low != 6'd0) && ((enb_low & (enb_low - 6'd1)) == 6'd0);
  assign multi_low = (enb_low != 6'd0) && !one_low;
  assign dec       = seg_decode(seg_s);
  assign mask_new  = mask_q | enb_low;

  // Shadow as it would look with the current sample written in
  always_comb begin
    shd_new_dig = shd_dig_q;
    shd_new_dp  = shd_dp_q;
    for (int i = 0; i < 6; i++) begin
      if (enb_low[i]) begin
        shd_new_dig[4*i +: 4] = dec;
        shd_new_dp[i]         = dp_s;
      end
    end
  end

  assign d0     = shd_new_dig[3:0];
  assign d1     = shd_new_dig[7:4];
  assign d2     = shd_new_dig[11:8];
  assign d3     = shd_new_dig[15:12];
  assign tv_new = (d0 <= 4'd9) && (d1 <= 4'd9) && (d2 <= 4'd9) && (d3 <= 4'd9);
  // Modulo-64 arithmetic gives the low 6 bits of the 7-bit 10*tens+units result
  assign sec_new = 6'(d1) * 6'd10 + 6'(d0);
  assign min_new = 6'(d3) * 6'd10 + 6'(d2);
  assign tmo     = (tcnt_q == TIMEOUT_VAL);

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    mask_d    = mask_q;
    digit_d   = digit_q;
    dp_d      = dp_q;
    sec_d     = sec_q;
    min_d     = min_q;
    tvld_d    = tvld_q;
    fvld_d    = 1'b0;
    link_d    = link_q;
    enb_err_d = 1'b0;
    seg_err_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (enb_chg) begin
          scnt_d  = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (any_chg) begin
          scnt_d = '0;
        end else if (scnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_WAIT;
        if (multi_low) begin
          enb_err_d = 1'b1;
          mask_d    = '0;
        end else if (one_low) begin
          seg_err_d = (dec == 4'hE);
          shd_dig_d = shd_new_dig;
          shd_dp_d  = shd_new_dp;
          if (mask_new == 6'h3F) begin
            mask_d  = '0;
            fvld_d  = 1'b1;
            digit_d = shd_new_dig;
            dp_d    = shd_new_dp;
            tvld_d  = tv_new;
            if (tv_new) begin
              sec_d = sec_new;
              min_d = min_new;
            end
          end else begin
            mask_d = mask_new;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Link watchdog: any enable activity revives the link; a stall drops it and discards the partial frame
    if (enb_chg) begin
      tcnt_d = '0;
      link_d = 1'b1;
    end else if (tmo) begin
      link_d = 1'b0;
      mask_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      scnt_q    <= '0;
      tcnt_q    <= '0;
      shd_dig_q <= 24'hFFFFFF;
      shd_dp_q  <= '0;
      mask_q    <= '0;
      digit_q   <= 24'hFFFFFF;
      dp_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      tvld_q    <= 1'b0;
      fvld_q    <= 1'b0;
      link_q    <= 1'b0;
      enb_err_q <= 1'b0;
      seg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      tcnt_q    <= tcnt_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      mask_q    <= mask_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      tvld_q    <= tvld_d;
      fvld_q    <= fvld_d;
      link_q    <= link_d;
      enb_err_q <= enb_err_d;
      seg_err_q <= seg_err_d;
    end
  end

`ifdef SEG_SCAN_RX_DP_MODE_EN
  logic [1:0] mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 2'b00;
    end else if (fvld_d) begin
      mode_q <= shd_new_dp[1:0];
    end
  end

  assign o_mode = mode_q;
`else
  assign o_mode = 2'b00;
`endif

  assign o_digit     = digit_q;
  assign o_dp        = dp_q;
  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_time_vld  = tvld_q;
  assign o_frame_vld = fvld_q;
  assign o_link_up   = link_q;
  assign o_enb_err   = enb_err_q;
  assign o_seg_err   = seg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_rx.sv
`default_nettype none
// tb_seg_scan_rx: randomized scan stimulus against a digit-slot reference model with a frame/error scoreboard. Rev 1.0
module tb_seg_scan_rx;

  localparam int TMO = 600;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  i_seg_enb;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [23:0] o_digit;
  logic [5:0]  o_dp, o_sec, o_min;
  logic        o_time_vld, o_frame_vld, o_link_up, o_enb_err, o_seg_err;
  logic [1:0]  o_mode;

  always #5 clk = ~clk;

  seg_scan_rx #(.SETTLE_CYC(4), .TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_seg_enb(i_seg_enb), .i_seg(i_seg), .i_seg_dp(i_seg_dp),
    .o_digit(o_digit), .o_dp(o_dp), .o_sec(o_sec), .o_min(o_min),
    .o_time_vld(o_time_vld), .o_frame_vld(o_frame_vld), .o_link_up(o_link_up),
    .o_enb_err(o_enb_err), .o_seg_err(o_seg_err), .o_mode(o_mode)
  );

  typedef struct packed {
    logic [23:0] digit;
    logic [5:0]  dp;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic        tvld;
    logic [1:0]  mode;
  } frame_t;

  frame_t exp_q[$];
  int     err_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  logic [6:0] pats [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};
  logic [6:0] bads [3]  = '{7'h01, 7'h40, 7'h3C};

  // Reference model: six digit slots, a seen-set, and the last shown time
  logic [3:0] m_dig [6];
  logic       m_dp  [6];
  logic [5:0] m_mask;
  int         m_sec, m_min;
  logic [5:0] m_prev_enb;
  bit         m_armed;
  int         m_since;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_dig[i] = 4'hF;
      m_dp[i]  = 1'b0;
    end
    m_mask = 6'd0; m_sec = 0; m_min = 0;
    m_prev_enb = 6'h3F; m_armed = 1'b0; m_since = 0;
  endtask

  task automatic model_sample(input logic [5:0] enb, input logic [6:0] seg, input logic dp);
    int nlow = 0;
    int k = 0;
    logic [3:0] d;
    frame_t f;
    for (int i = 0; i < 6; i++) if (!enb[i]) begin nlow++; k = i; end
    if (nlow == 0) return;
    if (nlow > 1) begin
      err_q.push_back(1);
      m_mask = 6'd0;
      return;
    end
    if (seg == 7'h00) d = 4'hF;
    else begin
      d = 4'hE;
      for (int v = 0; v < 10; v++) if (pats[v] == seg) d = 4'(v);
    end
    if (d == 4'hE) err_q.push_back(2);
    m_dig[k] = d; m_dp[k] = dp; m_mask[k] = 1'b1;
    if (m_mask == 6'h3F) begin
      m_mask  = 6'd0;
      f.digit = {m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      f.dp    = {m_dp[5], m_dp[4], m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      f.tvld  = (m_dig[0] <= 9) && (m_dig[1] <= 9) && (m_dig[2] <= 9) && (m_dig[3] <= 9);
      if (f.tvld) begin
        m_sec = (10 * m_dig[1] + m_dig[0]) % 64;
        m_min = (10 * m_dig[3] + m_dig[2]) % 64;
      end
      f.sec = 6'(m_sec);
      f.min = 6'(m_min);
`ifdef SEG_SCAN_RX_DP_MODE_EN
      f.mode = {m_dp[1], m_dp[0]};
`else
      f.mode = 2'b00;
`endif
      exp_q.push_back(f);
    end
  endtask

  // A held pattern is captured once per enable change if it stays put for >= 8 cycles; <= 4-cycle holds are glitches
  task automatic step(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int hold);
    if (enb != m_prev_enb) begin m_armed = 1'b1; m_since = 0; end
    if (hold >= 8 && m_armed) begin
      m_armed = 1'b0;
      model_sample(enb, seg, dp);
    end
    m_prev_enb = enb;
    i_seg_enb = enb; i_seg = seg; i_seg_dp = dp;
    repeat (hold) @(posedge clk);
    #1;
    m_since += hold;
    if (m_since >= TMO) m_mask = 6'd0;
  endtask

  task automatic scan(input int k, input int v, input logic dp, input int hold);
    logic [5:0] e;
    logic [6:0] s;
    e = 6'h3F; e[k] = 1'b0;
    s = (v > 9) ? 7'h00 : pats[v];
    step(e, s, dp, hold);
  endtask

  task automatic scan_frame(input int v0, v1, v2, v3, v4, v5, input logic [5:0] dps);
    scan(0, v0, dps[0], 40); scan(1, v1, dps[1], 40); scan(2, v2, dps[2], 40);
    scan(3, v3, dps[3], 40); scan(4, v4, dps[4], 40); scan(5, v5, dps[5], 40);
  endtask

  task automatic rand_frame();
    int v, r;
    logic [5:0] e;
    logic [6:0] s;
    for (int j = 0; j < 6; j++) begin
      v = (j == 1 || j == 3) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 9));
      r = $urandom_range(0, 15);
      s = pats[v];
      if (r == 0) s = 7'h00;
      else if (r == 1) s = bads[$urandom_range(0, 2)];
      e = 6'h3F; e[j] = 1'b0;
      if ($urandom_range(0, 5) == 0) step(e, 7'($urandom_range(0, 127)), 1'b0, $urandom_range(1, 3));
      step(e, s, 1'($urandom_range(0, 1)), $urandom_range(8, 16));
      if (j > 0 && $urandom_range(0, 5) == 0) scan(j - 1, $urandom_range(0, 9), 1'b0, 10);
    end
    if ($urandom_range(0, 7) == 0) step(6'h3F, 7'h7E, 1'b0, 10);
    if ($urandom_range(0, 7) == 0) step(6'b101011, 7'h30, 1'b0, 10);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".digit"}, o_digit, 24'hFFFFFF);
    check({tag, ".dp"}, o_dp, 6'd0);
    check({tag, ".sec"}, o_sec, 6'd0);
    check({tag, ".min"}, o_min, 6'd0);
    check({tag, ".mode"}, o_mode, 2'd0);
    check({tag, ".flags"}, {o_time_vld, o_frame_vld, o_link_up, o_enb_err, o_seg_err}, 5'd0);
  endtask

  frame_t mon_f;
  int     mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_frame_vld) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL frame: unexpected frame digit=%h expected none", o_digit);
        end else begin
          mon_f = exp_q.pop_front();
          check("frame.digit", o_digit, mon_f.digit);
          check("frame.dp", o_dp, mon_f.dp);
          check("frame.sec", o_sec, mon_f.sec);
          check("frame.min", o_min, mon_f.min);
          check("frame.tvld", o_time_vld, mon_f.tvld);
          check("frame.mode", o_mode, mon_f.mode);
        end
      end
      if (o_enb_err || o_seg_err) begin
        if (err_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL errpulse: unexpected pulse enb=%0b seg=%0b expected none", o_enb_err, o_seg_err);
        end else begin
          mon_e = err_q.pop_front();
          check("errpulse", {o_seg_err, o_enb_err}, mon_e);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1; i_seg_enb = 6'h3F; i_seg = 7'h00; i_seg_dp = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("link_init", o_link_up, 1'b0);

    // 12:34 with digits 4-5 blank
    scan(0, 4, 1'b0, 40);
    check("link_first", o_link_up, 1'b1);
    scan(1, 3, 1'b0, 40); scan(2, 2, 1'b0, 40); scan(3, 1, 1'b0, 40);
    scan(4, 15, 1'b0, 40); scan(5, 15, 1'b0, 40);
    check("t1.digit", o_digit, 24'hFF1234);
    check("t1.sec", o_sec, 6'd34);
    check("t1.min", o_min, 6'd12);
    check("t1.tvld", o_time_vld, 1'b1);

    // Glitchy digit0: only the settled 2 is captured
    step(6'b111110, 7'h7F, 1'b0, 2);
    step(6'b111110, 7'h00, 1'b0, 1);
    step(6'b111110, 7'h6D, 1'b0, 20);
    scan(1, 3, 1'b0, 40); scan(2, 2, 1'b0, 40); scan(3, 1, 1'b0, 40);
    scan(4, 15, 1'b0, 40); scan(5, 15, 1'b0, 40);
    check("t2.digit", o_digit, 24'hFF1232);

    // Two enables low, then a clean 23:45 frame
    scan(0, 7, 1'b0, 40); scan(1, 7, 1'b0, 40);
    step(6'b111100, 7'h7E, 1'b0, 20);
    scan_frame(5, 4, 3, 2, 15, 15, 6'd0);
    check("t3.sec", o_sec, 6'd45);
    check("t3.min", o_min, 6'd23);

    // Undecodable digit2: E shown, time held
    scan(0, 9, 1'b0, 40); scan(1, 5, 1'b0, 40);
    step(6'b111011, 7'h01, 1'b0, 40);
    scan(3, 0, 1'b0, 40); scan(4, 15, 1'b0, 40); scan(5, 15, 1'b0, 40);
    check("t4.digit2", o_digit[11:8], 4'hE);
    check("t4.tvld", o_time_vld, 1'b0);
    check("t4.sec", o_sec, 6'd45);
    check("t4.min", o_min, 6'd23);

    // Link stall discards the partial frame
    scan(0, 1, 1'b0, 40); scan(1, 1, 1'b0, 40); scan(2, 1, 1'b0, 40);
    step(6'b111011, pats[1], 1'b0, TMO + 100);
    check("t5.link_down", o_link_up, 1'b0);
    scan(3, 2, 1'b0, 40);
    check("t5.link_up", o_link_up, 1'b1);
    scan(4, 2, 1'b0, 40); scan(5, 2, 1'b0, 40);
    scan_frame(8, 5, 9, 5, 0, 0, 6'd0);

    // dp on digit1 only
    scan_frame(0, 0, 0, 1, 15, 15, 6'b000010);

    for (int n = 0; n < 25; n++) rand_frame();

    // Reset in the middle of a frame
    scan(0, 3, 1'b0, 20); scan(1, 3, 1'b0, 20); scan(2, 3, 1'b0, 20);
    step(6'h3F, 7'h00, 1'b0, 20);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("midreset");
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    scan(3, 1, 1'b0, 20); scan(4, 1, 1'b0, 20); scan(5, 1, 1'b0, 20);
    scan_frame(6, 5, 4, 2, 15, 15, 6'd0);

    repeat (30) @(posedge clk);
    #1;
    check("left.frames", exp_q.size(), 0);
    check("left.errs", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
